// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_done,
  output logic         if_stall,
  input  logic         d_rd,
  input  logic         d_wr,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_done,
  output logic         d_stall,
  output logic         d_err,
  output logic         sel,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_rd,
  output logic         mem_wr,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_done,
  input  logic         mem_stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_IF,
    S_WAIT_IF,
    S_ISSUE_D,
    S_WAIT_D
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched at grant so the command type stays stable even if the requester
  // drops d_rd/d_wr (or both are set) while the transaction is in flight.
  logic is_wr;

  logic d_req;
  logic f_req;
  logic grant_d;
  logic grant_f;
  logic complete;
  logic in_issue;
  logic in_wait;

  // A requester whose done pulse is showing is finishing its previous
  // transaction, so its still-held request must not be granted again.
  assign d_req    = (d_rd | d_wr) & ~d_done;
  assign f_req    = if_req & ~if_done;
  assign grant_d  = (state == S_IDLE) & d_req;
  assign grant_f  = (state == S_IDLE) & ~d_req & f_req;
  assign in_issue = (state == S_ISSUE_IF) | (state == S_ISSUE_D);
  assign in_wait  = (state == S_WAIT_IF) | (state == S_WAIT_D);
  // mem_done is only honoured when the command was accepted this cycle or
  // one is already outstanding; in IDLE or under mem_stall it is dropped.
  assign complete = (in_issue & ~mem_stall & mem_done) | (in_wait & mem_done);

  assign if_stall = if_req & ~if_done;
  assign d_stall  = (d_rd | d_wr) & ~d_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed data-over-fetch priority, one command in flight
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (d_req) begin
          state_nxt = S_ISSUE_D;
        end else if (f_req) begin
          state_nxt = S_ISSUE_IF;
        end
      end
      S_ISSUE_IF: begin
        if (!mem_stall) begin
          state_nxt = mem_done ? S_IDLE : S_WAIT_IF;
        end
      end
      S_WAIT_IF: begin
        if (mem_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE_D: begin
        if (!mem_stall) begin
          state_nxt = mem_done ? S_IDLE : S_WAIT_D;
        end
      end
      S_WAIT_D: begin
        if (mem_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Mux select and memory commands decoded purely from state
  always_comb begin
    sel    = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    case (state)
      S_ISSUE_IF: mem_rd = 1'b1;
      S_ISSUE_D: begin
        sel    = 1'b1;
        mem_rd = ~is_wr;
        mem_wr = is_wr;
      end
      S_WAIT_D:   sel = 1'b1;
      default: begin
        sel    = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
      end
    endcase
  end

  // Request capture at grant, read-data return and single-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_wr     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        is_wr     <= d_wr;
        d_err     <= d_rd & d_wr;
      end else if (grant_f) begin
        mem_addr <= if_addr;
        is_wr    <= 1'b0;
      end
      if (complete) begin
        if (sel) begin
          d_done <= 1'b1;
          if (!is_wr) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        d_err;
  logic        sel;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;

  typedef struct {
    logic        port;   // 0 = fetch, 1 = data
    logic [15:0] data;   // rdata expected on the requester when done pulses
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] model_if;
  logic [15:0] model_d;
  int          vectors = 0;
  int          miscompares = 0;

  mem_port_arbiter #(.N(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall), .d_err(d_err), .sel(sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    if_req = 0; if_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_done = 0; mem_stall = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    cyc(); cyc(); settle();
    vectors++; if ({sel, mem_rd, mem_wr, if_done, d_done, d_err} !== 6'b0) begin miscompares++; $display("FAIL rst_ctrl got=%b exp=000000", {sel, mem_rd, mem_wr, if_done, d_done, d_err}); end
    vectors++; if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin miscompares++; $display("FAIL rst_data got=%h exp=0", {if_rdata, d_rdata, mem_addr, mem_wdata}); end
    model_if = 0; model_d = 0;
    cyc(); rst = 0; mem_done = 1; mem_rdata = 16'hFFFF; settle();
    cyc(); mem_done = 0; settle();
    vectors++; if ({if_done, d_done, if_rdata} !== 18'h0) begin miscompares++; $display("FAIL idle_mem_done_ignored got=%h exp=0", {if_done, d_done, if_rdata}); end
  endtask

  task automatic test_fetch_single;
    cyc(); if_req = 1; if_addr = 16'h0040; settle();
    vectors++; if (if_stall !== 1'b1) begin miscompares++; $display("FAIL f1_stall_req got=%b exp=1", if_stall); end
    cyc(); settle();
    vectors++; if ({mem_rd, mem_wr, sel} !== 3'b100) begin miscompares++; $display("FAIL f1_cmd got=%b exp=100", {mem_rd, mem_wr, sel}); end
    vectors++; if (mem_addr !== 16'h0040) begin miscompares++; $display("FAIL f1_addr got=%h exp=0040", mem_addr); end
    mem_done = 1; mem_rdata = 16'hBEEF;
    exp_q.push_back('{1'b0, 16'hBEEF}); model_if = 16'hBEEF;
    cyc(); mem_done = 0; settle();
    vectors++; if (if_done !== 1'b1) begin miscompares++; $display("FAIL f1_done got=%b exp=1", if_done); end
    if (if_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL f1_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b0 || if_rdata !== e.data) begin miscompares++; $display("FAIL f1_sb got=%h exp=%h port%0d", if_rdata, e.data, e.port); end end
    end
    vectors++; if (if_stall !== 1'b0) begin miscompares++; $display("FAIL f1_stall_done got=%b exp=0", if_stall); end
    cyc(); if_req = 0; settle();
    vectors++; if ({if_done, mem_rd} !== 2'b00) begin miscompares++; $display("FAIL f1_pulse_end got=%b exp=00", {if_done, mem_rd}); end
  endtask

  task automatic test_priority;
    cyc(); d_rd = 1; d_addr = 16'h1000; if_req = 1; if_addr = 16'h0044; settle();
    vectors++; if ({if_stall, d_stall} !== 2'b11) begin miscompares++; $display("FAIL pr_stalls got=%b exp=11", {if_stall, d_stall}); end
    cyc(); settle();
    vectors++; if ({sel, mem_rd, mem_addr} !== {2'b11, 16'h1000}) begin miscompares++; $display("FAIL pr_grant_d got=%b/%b/%h exp=1/1/1000", sel, mem_rd, mem_addr); end
    vectors++; if (if_stall !== 1'b1) begin miscompares++; $display("FAIL pr_if_stall1 got=%b exp=1", if_stall); end
    mem_done = 1; mem_rdata = 16'h1111;
    exp_q.push_back('{1'b1, 16'h1111}); model_d = 16'h1111;
    cyc(); mem_done = 0; settle();
    vectors++; if ({d_done, d_stall, if_stall} !== 3'b101) begin miscompares++; $display("FAIL pr_d_done got=%b exp=101", {d_done, d_stall, if_stall}); end
    if (d_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL pr_d_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b1 || d_rdata !== e.data) begin miscompares++; $display("FAIL pr_d_sb got=%h exp=%h port%0d", d_rdata, e.data, e.port); end end
    end
    cyc(); d_rd = 0; settle();
    vectors++; if ({sel, mem_rd, mem_addr} !== {2'b01, 16'h0044}) begin miscompares++; $display("FAIL pr_grant_f got=%b/%b/%h exp=0/1/0044", sel, mem_rd, mem_addr); end
    vectors++; if (if_stall !== 1'b1) begin miscompares++; $display("FAIL pr_if_stall2 got=%b exp=1", if_stall); end
    mem_done = 1; mem_rdata = 16'h2222;
    exp_q.push_back('{1'b0, 16'h2222}); model_if = 16'h2222;
    cyc(); mem_done = 0; settle();
    vectors++; if ({if_done, d_done} !== 2'b10) begin miscompares++; $display("FAIL pr_f_done got=%b exp=10", {if_done, d_done}); end
    if (if_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL pr_f_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b0 || if_rdata !== e.data) begin miscompares++; $display("FAIL pr_f_sb got=%h exp=%h port%0d", if_rdata, e.data, e.port); end end
    end
    vectors++; if (d_rdata !== model_d) begin miscompares++; $display("FAIL pr_d_hold got=%h exp=%h", d_rdata, model_d); end
    cyc(); if_req = 0; settle();
  endtask

  task automatic test_write_stall;
    cyc(); d_wr = 1; d_addr = 16'h2002; d_wdata = 16'h1234; settle();
    for (int k = 0; k < 4; k++) begin
      cyc(); mem_stall = (k < 3); mem_done = (k == 1); settle();
      vectors++; if ({mem_wr, mem_rd, sel, mem_addr, mem_wdata} !== {3'b101, 16'h2002, 16'h1234}) begin
        miscompares++; $display("FAIL wr_hold%0d got=%b%b%b/%h/%h exp=101/2002/1234", k, mem_wr, mem_rd, sel, mem_addr, mem_wdata);
      end
    end
    cyc(); mem_stall = 0; mem_done = 1; mem_rdata = 16'hDEAD; settle();
    vectors++; if ({mem_wr, sel, d_done} !== 3'b010) begin miscompares++; $display("FAIL wr_wait got=%b exp=010", {mem_wr, sel, d_done}); end
    exp_q.push_back('{1'b1, model_d});
    cyc(); mem_done = 0; settle();
    vectors++; if ({d_done, sel} !== 2'b10) begin miscompares++; $display("FAIL wr_done got=%b exp=10", {d_done, sel}); end
    if (d_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL wr_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b1 || d_rdata !== e.data) begin miscompares++; $display("FAIL wr_sb got=%h exp=%h port%0d", d_rdata, e.data, e.port); end end
    end
    cyc(); d_wr = 0; settle();
    vectors++; if (d_done !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_end got=%b exp=0", d_done); end
  endtask

  task automatic test_latency4;
    int waited;
    cyc(); if_req = 1; if_addr = 16'h0080; settle();
    cyc(); settle();
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL lat_issue got=%b exp=1", mem_rd); end
    for (int k = 0; k < 2; k++) begin
      cyc(); settle();
      vectors++; if ({mem_rd, if_done, if_stall} !== 3'b001) begin miscompares++; $display("FAIL lat_wait%0d got=%b exp=001", k, {mem_rd, if_done, if_stall}); end
    end
    cyc(); mem_done = 1; mem_rdata = 16'hA5A5; settle();
    exp_q.push_back('{1'b0, 16'hA5A5}); model_if = 16'hA5A5;
    waited = 0;
    do begin
      cyc(); mem_done = 0; settle(); waited++;
    end while (if_done !== 1'b1 && waited < 6);
    vectors++; if (waited != 1) begin miscompares++; $display("FAIL lat_done_delay got=%0d exp=1", waited); end
    if (if_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL lat_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b0 || if_rdata !== e.data) begin miscompares++; $display("FAIL lat_sb got=%h exp=%h port%0d", if_rdata, e.data, e.port); end end
    end
    cyc(); if_req = 0; settle();
    vectors++; if (if_done !== 1'b0) begin miscompares++; $display("FAIL lat_single_pulse got=%b exp=0", if_done); end
  endtask

  task automatic test_rdwr_err;
    cyc(); d_rd = 1; d_wr = 1; d_addr = 16'h3000; d_wdata = 16'h5678; settle();
    cyc(); settle();
    vectors++; if ({mem_wr, mem_rd, d_err, mem_wdata} !== {3'b101, 16'h5678}) begin miscompares++; $display("FAIL err_issue got=%b%b%b/%h exp=101/5678", mem_wr, mem_rd, d_err, mem_wdata); end
    mem_done = 1; mem_rdata = 16'hCCCC;
    exp_q.push_back('{1'b1, model_d});
    cyc(); mem_done = 0; settle();
    vectors++; if ({d_done, d_err} !== 2'b10) begin miscompares++; $display("FAIL err_done got=%b exp=10", {d_done, d_err}); end
    if (d_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL err_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b1 || d_rdata !== e.data) begin miscompares++; $display("FAIL err_sb got=%h exp=%h port%0d", d_rdata, e.data, e.port); end end
    end
    cyc(); d_rd = 0; d_wr = 0; settle();
    vectors++; if ({d_done, d_err} !== 2'b00) begin miscompares++; $display("FAIL err_once got=%b exp=00", {d_done, d_err}); end
  endtask

  task automatic test_reset_in_wait;
    cyc(); d_rd = 1; d_addr = 16'h4000; settle();
    cyc(); settle();
    cyc(); settle();
    vectors++; if ({sel, mem_rd} !== 2'b10) begin miscompares++; $display("FAIL rw_in_wait got=%b exp=10", {sel, mem_rd}); end
    cyc(); rst = 1; settle();
    cyc(); rst = 0; d_rd = 0; mem_done = 1; mem_rdata = 16'h9999; settle();
    model_if = 0; model_d = 0;
    vectors++; if ({sel, mem_rd, mem_wr, if_done, d_done, d_err} !== 6'b0) begin miscompares++; $display("FAIL rw_ctrl got=%b exp=000000", {sel, mem_rd, mem_wr, if_done, d_done, d_err}); end
    vectors++; if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== {model_if, model_d, 32'h0}) begin miscompares++; $display("FAIL rw_data got=%h exp=0", {if_rdata, d_rdata, mem_addr, mem_wdata}); end
    cyc(); mem_done = 0; if_req = 1; if_addr = 16'h0050; settle();
    vectors++; if ({d_done, d_rdata} !== 17'h0) begin miscompares++; $display("FAIL rw_late_done got=%h exp=0", {d_done, d_rdata}); end
    cyc(); settle();
    vectors++; if ({mem_rd, sel, mem_addr} !== {2'b10, 16'h0050}) begin miscompares++; $display("FAIL rw_refetch got=%b%b/%h exp=10/0050", mem_rd, sel, mem_addr); end
    mem_done = 1; mem_rdata = 16'h7777;
    exp_q.push_back('{1'b0, 16'h7777}); model_if = 16'h7777;
    cyc(); mem_done = 0; settle();
    vectors++; if (if_done !== 1'b1) begin miscompares++; $display("FAIL rw_f_done got=%b exp=1", if_done); end
    if (if_done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin miscompares++; $display("FAIL rw_sb got=done exp=none"); end
      else begin e = exp_q.pop_front(); if (e.port !== 1'b0 || if_rdata !== e.data) begin miscompares++; $display("FAIL rw_sb got=%h exp=%h port%0d", if_rdata, e.data, e.port); end end
    end
    cyc(); if_req = 0; settle();
  endtask

  initial begin
    test_reset();
    test_fetch_single();
    test_priority();
    test_write_stall();
    test_latency4();
    test_rdwr_err();
    test_reset_in_wait();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch and data-access stages of the pipeline.
- Captures each request and drives the address/data select (sel) for the 16-bit 2:1 muxes in front of the memory port.
- Issues one memory command at a time and waits for the memory's done handshake.
- Returns read data and a one-cycle done pulse to the requester; stalls the losing or waiting requester.

Parameters:
N, 16, address and data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch read request, held until if_done
if_addr  in  N  fetch address
if_rdata  out  N  fetch read data, registered
if_done  out  1  one-cycle fetch completion pulse
if_stall  out  1  fetch stage must hold
d_rd  in  1  data read request, held until d_done
d_wr  in  1  data write request, held until d_done
d_addr  in  N  data address
d_wdata  in  N  write data
d_rdata  out  N  data read data, registered
d_done  out  1  one-cycle data completion pulse
d_stall  out  1  data stage must hold
d_err  out  1  one-cycle pulse: d_rd and d_wr both set at grant
sel  out  1  mux select: 0 = fetch path, 1 = data path
mem_addr  out  N  latched address to memory
mem_wdata  out  N  latched write data to memory
mem_rd  out  1  memory read command
mem_wr  out  1  memory write command
mem_rdata  in  N  memory read data, valid with mem_done
mem_done  in  1  memory completion
mem_stall  in  1  memory cannot accept command this cycle

Behaviour:
- Reset values: state IDLE; all outputs 0, including rdata registers, sel, mem_addr and mem_wdata.
- FSM states: IDLE, ISSUE_IF, WAIT_IF, ISSUE_D, WAIT_D.
- IDLE arbitration:
  - Fixed priority: data over fetch.
  - A requester whose done is high this cycle is ignored.
  - On grant, latch addr (and wdata for data) into mem_addr/mem_wdata, then go to ISSUE_x.
  - If d_rd and d_wr are both set: treat as a write and pulse d_err on the next cycle.
- ISSUE_x:
  - mem_rd (fetch or data read) or mem_wr (data write) is high.
  - If mem_stall: hold the command and stay in ISSUE_x.
  - Else if mem_done in the same cycle: complete (see below).
  - Else go to WAIT_x.
- WAIT_x:
  - Commands low.
  - On mem_done: complete; otherwise stay.
- Completion:
  - For reads, latch mem_rdata into x_rdata.
  - Next cycle: x_done = 1 for exactly one cycle and state = IDLE.
  - x_rdata holds until that requester's next read completes; writes leave d_rdata unchanged.
- sel = 1 in ISSUE_D/WAIT_D, else 0. sel and the commands are decoded from state; sel changes only on state transitions.
- Stall outputs:
  - if_stall = if_req & ~if_done.
  - d_stall = (d_rd | d_wr) & ~d_done.
  - Both are combinational.
- Minimum latency:
  - Request seen in IDLE at cycle t, command at t+1.
  - Single-cycle memory (mem_done at t+1) gives done at t+2.
- Fetch can wait indefinitely while data requests back-to-back. This is acceptable because the pipeline stalls fetch during data access.
- mem_done arriving in IDLE, or mem_done with mem_stall high, is ignored.
- rst in any state:
  - Next cycle in IDLE with all outputs 0.
  - The outstanding transaction is abandoned; no done pulse.
  - A late mem_done is ignored.
- Requester contract: deassert or change the request the cycle after done. If req is still high in IDLE after its done cycle, it is a new request.

Test Plan:
- Fetch only, if_addr=0x0040, memory returns 0xBEEF at the ISSUE cycle with no stall -> mem_rd=1 and sel=0 at t+1; if_done=1 and if_rdata=0xBEEF at t+2; if_stall=0 at t+2.
- d_rd and if_req raised in the same cycle, d_addr=0x1000 -> data granted first (sel=1, mem_addr=0x1000); fetch issued after d_done; if_stall high throughout.
- d_wr to 0x2002 with d_wdata=0x1234, mem_stall high for 3 cycles -> mem_wr held 4 cycles with mem_wdata=0x1234; d_done one cycle after mem_done; d_rdata unchanged.
- Memory latency 4: mem_done 3 cycles after issue with mem_rdata=0xA5A5 -> stays in WAIT_IF; if_rdata=0xA5A5 and single if_done pulse exactly one cycle after mem_done.
- d_rd and d_wr both set -> write issued, d_err pulses once, d_done once.
- rst asserted in WAIT_D, then mem_done pulsed next cycle -> all outputs 0, no d_done; next if_req serviced normally.
